spec_return_stack_buffer: RTL and testbench



---
 rtl/riscv_types_pkg.sv | 7 +
 rtl/rsb_ckpt_file.sv | 31 +++
 rtl/spec_return_stack_buffer.sv | 122 ++++++++++++
 tb/tb_spec_return_stack_buffer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/riscv_types_pkg.sv
// Shared fetch/predictor type and sizing defaults for the RISC-V front end.
package riscv_types_pkg;

    localparam int RSB_DEPTH_DEFAULT    = 8;
    localparam int RSB_NUM_CKPT_DEFAULT = 4;

endpackage

// File: rtl/rsb_ckpt_file.sv
// Checkpoint register file for the return stack buffer: one write port for
// saves, one combinational read port for restores.
module rsb_ckpt_file #(
    parameter int  NUM_CKPT = 4,
    parameter int  DATA_W   = 8,
    localparam int IDX_W    = $clog2(NUM_CKPT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] slot_q [NUM_CKPT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            slot_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = slot_q[rd_idx_i];

endmodule

// File: rtl/spec_return_stack_buffer.sv
// Speculative return stack buffer: circular entry array with overwrite-on-full,
// plus checkpoint/restore of {tos, count, top entry} for mispredict repair.
module spec_return_stack_buffer
    import riscv_types_pkg::*;
#(
    parameter int  ADDR_WIDTH  = 32,
    parameter int  STACK_DEPTH = RSB_DEPTH_DEFAULT,
    parameter int  NUM_CKPT    = RSB_NUM_CKPT_DEFAULT,
    localparam int PTR_W       = $clog2(STACK_DEPTH),
    localparam int CKPT_W      = $clog2(NUM_CKPT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_en_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic                  pop_en_i,
    input  logic                  ckpt_save_i,
    input  logic [CKPT_W-1:0]     ckpt_idx_i,
    input  logic                  restore_i,
    input  logic [CKPT_W-1:0]     restore_idx_i,
    output logic [ADDR_WIDTH-1:0] top_addr_o,
    output logic                  top_valid_o,
    output logic [PTR_W:0]        count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    typedef struct packed {
        logic [PTR_W-1:0]      tos;
        logic [PTR_W:0]        count;
        logic [ADDR_WIDTH-1:0] top_addr;
    } ckpt_t;

    localparam int             CKPT_DATA_W = $bits(ckpt_t);
    localparam logic [PTR_W:0] COUNT_FULL  = STACK_DEPTH[PTR_W:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return p - PTR_W'(1);
    endfunction

    logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PTR_W-1:0]      tos_q;
    logic [PTR_W:0]        count_q;
    logic                  overflow_q;
    logic                  underflow_q;

    ckpt_t                 ckpt_wr;
    ckpt_t                 ckpt_rd;
    logic [PTR_W-1:0]      tos_inc;
    logic                  stack_empty;

    assign tos_inc     = ptr_inc(tos_q);
    assign stack_empty = (count_q == '0);

    // Snapshot is the pre-update state, i.e. exactly what the outputs show this cycle.
    assign ckpt_wr = '{tos: tos_q, count: count_q, top_addr: stack_q[tos_q]};

    rsb_ckpt_file #(
        .NUM_CKPT (NUM_CKPT),
        .DATA_W   (CKPT_DATA_W)
    ) u_ckpt_file (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (ckpt_save_i && !restore_i),
        .wr_idx_i  (ckpt_idx_i),
        .wr_data_i (ckpt_wr),
        .rd_idx_i  (restore_idx_i),
        .rd_data_o (ckpt_rd)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (flush_i) begin
                count_q <= '0;
            end else if (restore_i) begin
                // Only the top entry is repaired; deeper wrapped entries stay stale.
                tos_q                <= ckpt_rd.tos;
                count_q              <= ckpt_rd.count;
                stack_q[ckpt_rd.tos] <= ckpt_rd.top_addr;
            end else if (push_en_i && pop_en_i && !stack_empty) begin
                stack_q[tos_q] <= push_addr_i;
            end else if (push_en_i) begin
                tos_q            <= tos_inc;
                stack_q[tos_inc] <= push_addr_i;
                if (count_q == COUNT_FULL) begin
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + (PTR_W+1)'(1);
                end
            end else if (pop_en_i) begin
                if (stack_empty) begin
                    underflow_q <= 1'b1;
                end else begin
                    tos_q   <= ptr_dec(tos_q);
                    count_q <= count_q - (PTR_W+1)'(1);
                end
            end
        end
    end

    assign top_addr_o  = stack_q[tos_q];
    assign top_valid_o = !stack_empty;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_spec_return_stack_buffer.sv
// Scoreboard bench for spec_return_stack_buffer: each driven cycle queues the
// expected outputs, which are popped and compared one cycle later.
module tb_spec_return_stack_buffer;

    localparam int AW = 32;
    localparam int SD = 8;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst, flush, push_en, pop_en, ckpt_save, restore;
    logic [AW-1:0] push_addr;
    logic [1:0]    ckpt_idx, restore_idx;
    logic [AW-1:0] top_addr;
    logic          top_valid, overflow, underflow;
    logic [3:0]    count;

    always #5 clk = ~clk;

    spec_return_stack_buffer #(
        .ADDR_WIDTH  (AW),
        .STACK_DEPTH (SD),
        .NUM_CKPT    (NC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .push_en_i     (push_en),
        .push_addr_i   (push_addr),
        .pop_en_i      (pop_en),
        .ckpt_save_i   (ckpt_save),
        .ckpt_idx_i    (ckpt_idx),
        .restore_i     (restore),
        .restore_idx_i (restore_idx),
        .top_addr_o    (top_addr),
        .top_valid_o   (top_valid),
        .count_o       (count),
        .overflow_o    (overflow),
        .underflow_o   (underflow)
    );

    typedef struct {
        string         name;
        logic [AW-1:0] top;
        logic          vld;
        logic [3:0]    cnt;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step     = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; push_en = 0; pop_en = 0; ckpt_save = 0; restore = 0;
        push_addr = '0; ckpt_idx = '0; restore_idx = '0;
    endtask

    // One clock: drive stimulus, queue expectation, then compare after the edge.
    task automatic cyc(input string name, input bit r, input bit fl, input bit pu, input bit po,
                       input logic [AW-1:0] a, input bit sv, input int si, input bit rs, input int ri,
                       input logic [AW-1:0] et, input bit ev, input int ec, input bit eo, input bit eu);
        exp_t e;
        rst = r; flush = fl; push_en = pu; pop_en = po; push_addr = a;
        ckpt_save = sv; ckpt_idx = si[1:0]; restore = rs; restore_idx = ri[1:0];
        sb.push_back('{name, et, ev, ec[3:0], eo, eu});
        @(posedge clk);
        #1;
        idle_inputs();
        step++;
        e = sb.pop_front();
        check_eq($sformatf("%s#%0d top", e.name, step), 64'(top_addr), 64'(e.top));
        check_eq($sformatf("%s#%0d valid", e.name, step), 64'(top_valid), 64'(e.vld));
        check_eq($sformatf("%s#%0d count", e.name, step), 64'(count), 64'(e.cnt));
        check_eq($sformatf("%s#%0d overflow", e.name, step), 64'(overflow), 64'(e.ovf));
        check_eq($sformatf("%s#%0d underflow", e.name, step), 64'(underflow), 64'(e.unf));
    endtask

    task automatic do_push(input logic [AW-1:0] a, input int ec, input bit eo);
        cyc("push", 0, 0, 1, 0, a, 0, 0, 0, 0, a, 1, ec, eo, 0);
    endtask

    task automatic do_pop(input logic [AW-1:0] et, input int ec, input bit eu);
        cyc("pop", 0, 0, 0, 1, '0, 0, 0, 0, 0, et, ec != 0, ec, 0, eu);
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;
        cyc("reset", 1, 0, 0, 0, '0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);

        // Basic push/pop
        do_push(32'h100, 1, 0);
        do_push(32'h200, 2, 0);
        do_push(32'h300, 3, 0);
        do_pop(32'h200, 2, 0);
        do_pop(32'h100, 1, 0);
        do_pop(32'h0, 0, 0);

        // Overflow: ninth push overwrites the oldest entry
        for (int k = 1; k <= 8; k++) do_push(32'(k * 16), k, 0);
        do_push(32'h90, 8, 1);
        for (int j = 1; j <= 7; j++) do_pop(32'(32'h90 - j * 16), 8 - j, 0);
        do_pop(32'h90, 0, 0);
        do_pop(32'h90, 0, 1);
        cyc("idle", 0, 0, 0, 0, '0, 0, 0, 0, 0, 32'h90, 0, 0, 0, 0);

        // Push+pop replaces top; on an empty stack it acts as a push
        do_push(32'hA0, 1, 0);
        cyc("pushpop", 0, 0, 1, 1, 32'hB0, 0, 0, 0, 0, 32'hB0, 1, 1, 0, 0);
        do_pop(32'h90, 0, 0);
        cyc("pushpop_empty", 0, 0, 1, 1, 32'hC0, 0, 0, 0, 0, 32'hC0, 1, 1, 0, 0);

        // Checkpoint and repair of the top entry
        do_push(32'h40, 2, 0);
        cyc("save2", 0, 0, 0, 0, '0, 1, 2, 0, 0, 32'h40, 1, 2, 0, 0);
        do_pop(32'hC0, 1, 0);
        do_push(32'h99, 2, 0);
        do_push(32'hAA, 3, 0);
        cyc("restore2", 0, 0, 0, 0, '0, 0, 0, 1, 2, 32'h40, 1, 2, 0, 0);

        // Same-slot save+restore: restore wins, save dropped (slot 1 stays zero)
        cyc("save_rest1", 0, 0, 0, 0, '0, 1, 1, 1, 1, 32'h0, 0, 0, 0, 0);
        cyc("restore1", 0, 0, 0, 0, '0, 0, 0, 1, 1, 32'h0, 0, 0, 0, 0);
        cyc("restore2b", 0, 0, 0, 0, '0, 0, 0, 1, 2, 32'h40, 1, 2, 0, 0);

        // Flush beats push; restore beats pop
        cyc("flush_push", 0, 1, 1, 0, 32'h55, 0, 0, 0, 0, 32'h40, 0, 0, 0, 0);
        cyc("restore_pop", 0, 0, 0, 1, '0, 0, 0, 1, 2, 32'h40, 1, 2, 0, 0);
        do_push(32'h66, 3, 0);
        // Save in a push cycle captures the pre-push state
        cyc("save0_push", 0, 0, 1, 0, 32'h77, 1, 0, 0, 0, 32'h77, 1, 4, 0, 0);
        cyc("restore0", 0, 0, 0, 0, '0, 0, 0, 1, 0, 32'h66, 1, 3, 0, 0);

        // Reset during restore clears everything, including checkpoints
        cyc("rst_restore", 1, 0, 0, 0, '0, 0, 0, 1, 2, 32'h0, 0, 0, 0, 0);
        cyc("restore_after_rst", 0, 0, 0, 0, '0, 0, 0, 1, 2, 32'h0, 0, 0, 0, 0);

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
